dte_ar_deposit: RTL and testbench
=================================

// Module: dte_ar_deposit
// PURPOSE
// Front-end (DTE) diagnostic path into and out of the EBOX data path AR register.
// Assembles a 36-bit word from 12-bit front-end chunks, then drives the data path AR override (ARvalue/overrideAR) for exactly one clock.
// Examine reads the data path AR back and returns it as 12-bit chunks.
// Sits directly upstream of the data path AR mux (deposit) and downstream of AR (examine); clocked with the data path clock.
// PARAMETERS
// CHUNK_W    12   width of one front-end transfer chunk
// NCHUNK     3    chunks per word; CHUNK_W*NCHUNK must equal 36
// ARM_TMO    255  cycles to wait for ebox_halted before an armed deposit aborts with err
// PORTS
// clk            in   1      data path clock; the only clock
// reset          in   1      synchronous, active-high
// cmd_valid      in   1      front-end command strobe
// cmd_op         in   2      00 NOP, 01 DEPOSIT, 10 EXAMINE, 11 ABORT
// cmd_ready      out  1      block accepts a command this cycle
// wr_valid       in   1      deposit chunk valid
// wr_data        in   12     deposit chunk; first chunk is AR[0:11], MSB first
// wr_ready       out  1      deposit chunk accepted this cycle
// rd_valid       out  1      examine chunk valid
// rd_data        out  12     examine chunk; first chunk is AR[0:11]
// rd_ready       in   1      front end takes the examine chunk
// ebox_halted    in   1      EBOX stopped; override is permitted only while this is high
// ar_in          in   36     data path AR, bits [0:35]
// ar_value       out  36     to DTE.ARvalue
// override_ar    out  1      to DTE.overrideAR; one-cycle pulse
// busy           out  1      state != IDLE
// err            out  1      sticky; deposit timed out or was aborted; cleared by the next accepted command
// BEHAVIOUR
// Reset: state IDLE; chunk count 0; staging register 0; every output 0, except cmd_ready = 1.
// cmd_ready is high only in IDLE. A command is accepted on cmd_valid & cmd_ready.
// NOP is accepted and ignored. ABORT while in IDLE only clears err.
// FSM states: IDLE, COLLECT, ARM, OVR, CAPTURE, SEND.
// DEPOSIT: IDLE->COLLECT. Count resets to 0 and staging to 0.
// COLLECT: wr_ready = 1. Each wr_valid writes staging[k*12 +: 12] in AR bit order and increments k.
//   When chunk NCHUNK-1 is accepted, go to ARM on the next cycle. wr_ready is 0 in every other state.
// ARM: waits for ebox_halted, counting cycles.
//   If ebox_halted is high on entry, go to OVR on the next cycle.
//   At ARM_TMO cycles with ebox_halted still low: set err, go to IDLE, no override.
// OVR: override_ar = 1 for exactly this one cycle; ar_value = staging.
//   The data path loads AR at the end of this cycle. Next state IDLE.
// ar_value holds staging in every state; the AR mux ignores it unless override_ar is high.
// EXAMINE: IDLE->CAPTURE. CAPTURE samples ar_in into the shift register and stays one cycle; then SEND.
// SEND: rd_valid = 1 with rd_data = the current chunk. On rd_valid & rd_ready, advance to the next chunk.
//   After chunk NCHUNK-1 is taken, go to IDLE. rd_data must stay stable while rd_valid & !rd_ready.
// ABORT: cmd_valid with op=ABORT is sampled in any state, even while cmd_ready=0.
//   In COLLECT, ARM or SEND it forces IDLE on the next cycle and sets err (SEND only drops rd_valid).
//   ABORT during OVR cannot cancel the pulse already in progress.
// Simultaneous ABORT and wr_valid in COLLECT: ABORT wins and the chunk is discarded.
// wr_valid outside COLLECT and rd_ready outside SEND are ignored.
// Reset mid-operation: returns to IDLE within the same edge; override_ar is 0 on the next cycle; staging is cleared.
// Latency: last chunk -> override_ar is 2 cycles when halted. EXAMINE accept -> first rd_valid is 2 cycles.
// STRUCTURE
// Shared package gets: the cmd_op enum (NOP/DEPOSIT/EXAMINE/ABORT), the FSM state enum, and CHUNK_W/NCHUNK defaults.
// Top level wires override_ar/ar_value into iDTE.overrideAR/ARvalue and EDP.AR into ar_in.
// Single sub-module: chunk_shifter, a 36-bit staging/shift register with load-chunk, parallel-load and shift-out controls.
//   The FSM and timeout counter stay in the top level.
// TESTING
// Halted; DEPOSIT; chunks 12'o7777, 12'o0000, 12'o1234 -> one override_ar pulse 2 cycles later, ar_value = 36'o777700001234.
// ar_in = 36'o123456765432; EXAMINE; rd_ready always 1 -> rd_data 12'o1234, 12'o5676, 12'o5432 on 3 consecutive cycles.
// Deposit with ebox_halted = 0 for ARM_TMO cycles -> err = 1, override_ar never asserted, back to IDLE.
// Examine with rd_ready low for 5 cycles on chunk 1 -> rd_data stable, then chunks delivered in order.
// ABORT after 2 deposit chunks, then a fresh DEPOSIT -> err set then cleared, staging restarts at chunk 0.
// reset asserted in ARM or SEND -> next cycle: IDLE, all outputs 0, cmd_ready = 1.

Source files
------------

// File: rtl/dte_ar_deposit_pkg.sv
// Shared types and default sizes for the DTE AR deposit/examine path.
package dte_ar_deposit_pkg;

  localparam int DEF_CHUNK_W = 12;
  localparam int DEF_NCHUNK  = 3;
  localparam int DEF_ARM_TMO = 255;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_DEPOSIT = 2'b01,
    OP_EXAMINE = 2'b10,
    OP_ABORT   = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ARM,
    ST_OVR,
    ST_CAPTURE,
    ST_SEND
  } state_e;

endpackage

// File: rtl/dte_ar_deposit_chunk_shifter.sv
// Staging/shift register shared by deposit (chunk writes) and examine (parallel load, rotate out).
// Chunk 0 occupies the most significant bits, matching AR bit 0 as the MSB.
module dte_ar_deposit_chunk_shifter
  import dte_ar_deposit_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int NCHUNK  = DEF_NCHUNK,
  parameter int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      load_chunk_i,
  input  logic [IDX_W-1:0]          chunk_idx_i,
  input  logic [CHUNK_W-1:0]        chunk_i,
  input  logic                      load_word_i,
  input  logic [CHUNK_W*NCHUNK-1:0] word_i,
  input  logic                      shift_i,
  output logic [CHUNK_W*NCHUNK-1:0] word_o,
  output logic [CHUNK_W-1:0]        chunk_o
);

  localparam int WORD_W = CHUNK_W * NCHUNK;

  logic [WORD_W-1:0] stage_q;
  logic [WORD_W-1:0] stage_d;

  // Shift-out rotates, so a completed examine leaves the captured word in place.
  always_comb begin
    stage_d = stage_q;
    if (clear_i) begin
      stage_d = '0;
    end else if (load_word_i) begin
      stage_d = word_i;
    end else if (shift_i) begin
      stage_d = {stage_q[WORD_W-CHUNK_W-1:0], stage_q[WORD_W-1 -: CHUNK_W]};
    end else if (load_chunk_i) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (chunk_idx_i == IDX_W'(k)) begin
          stage_d[WORD_W-1-k*CHUNK_W -: CHUNK_W] = chunk_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign word_o  = stage_q;
  assign chunk_o = stage_q[WORD_W-1 -: CHUNK_W];

endmodule

// File: rtl/dte_ar_deposit.sv
// Front-end diagnostic deposit into, and examine out of, the EBOX data path AR register.
// A deposit is assembled from chunks and applied as a single-cycle AR override while the EBOX is halted.
module dte_ar_deposit
  import dte_ar_deposit_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int NCHUNK  = DEF_NCHUNK,
  parameter int ARM_TMO = DEF_ARM_TMO
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  output logic                      cmd_ready,
  input  logic                      wr_valid,
  input  logic [CHUNK_W-1:0]        wr_data,
  output logic                      wr_ready,
  output logic                      rd_valid,
  output logic [CHUNK_W-1:0]        rd_data,
  input  logic                      rd_ready,
  input  logic                      ebox_halted,
  input  logic [CHUNK_W*NCHUNK-1:0] ar_in,
  output logic [CHUNK_W*NCHUNK-1:0] ar_value,
  output logic                      override_ar,
  output logic                      busy,
  output logic                      err
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TMO_W = $clog2(ARM_TMO + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TMO - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic             sh_clear, sh_load_chunk, sh_load_word, sh_shift;
  logic [CHUNK_W-1:0] sh_chunk;
  cmd_op_e          op;
  logic             abort_req;

  assign op        = cmd_op_e'(cmd_op);
  assign abort_req = cmd_valid && (op == OP_ABORT);

  dte_ar_deposit_chunk_shifter #(
    .CHUNK_W (CHUNK_W),
    .NCHUNK  (NCHUNK),
    .IDX_W   (IDX_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (sh_clear),
    .load_chunk_i (sh_load_chunk),
    .chunk_idx_i  (idx_q),
    .chunk_i      (wr_data),
    .load_word_i  (sh_load_word),
    .word_i       (ar_in),
    .shift_i      (sh_shift),
    .word_o       (ar_value),
    .chunk_o      (sh_chunk)
  );

  // ABORT is honoured only where it can safely cancel: COLLECT, ARM and SEND.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    err_d         = err_q;
    sh_clear      = 1'b0;
    sh_load_chunk = 1'b0;
    sh_load_word  = 1'b0;
    sh_shift      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          idx_d = '0;
          if (op == OP_DEPOSIT) begin
            state_d  = ST_COLLECT;
            sh_clear = 1'b1;
          end else if (op == OP_EXAMINE) begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_COLLECT: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (wr_valid) begin
          sh_load_chunk = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_ARM;
            tmo_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_ARM: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (ebox_halted) begin
          state_d = ST_OVR;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_OVR: begin
        state_d = ST_IDLE;
      end
      ST_CAPTURE: begin
        sh_load_word = 1'b1;
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (rd_ready) begin
          sh_shift = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wr_ready    = (state_q == ST_COLLECT);
  assign rd_valid    = (state_q == ST_SEND);
  assign rd_data     = rd_valid ? sh_chunk : '0;
  assign override_ar = (state_q == ST_OVR);
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_dte_ar_deposit.sv
// Self-checking bench for dte_ar_deposit: directed vector table, corner sequences, and
// randomized traffic compared each cycle against a queue-based behavioural model.
module tb_dte_ar_deposit;

  localparam int ARM_TMO = 255;
  localparam logic [35:0] AR_DEFAULT = 36'o123456765432;

  localparam int K_IDLE    = 0;
  localparam int K_COLLECT = 1;
  localparam int K_ARM     = 2;
  localparam int K_OVR     = 3;
  localparam int K_CAPTURE = 4;
  localparam int K_SEND    = 5;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, wr_valid, rd_ready, ebox_halted;
  logic [1:0]  cmd_op;
  logic [11:0] wr_data, rd_data;
  logic [35:0] ar_in, ar_value;
  logic        cmd_ready, wr_ready, rd_valid, override_ar, busy, err;

  always #5 clk = ~clk;

  dte_ar_deposit #(.ARM_TMO(ARM_TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .ebox_halted (ebox_halted),
    .ar_in       (ar_in),
    .ar_value    (ar_value),
    .override_ar (override_ar),
    .busy        (busy),
    .err         (err)
  );

  typedef struct {
    logic        rst;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic        wrValid;
    logic [11:0] wrData;
    logic        rdReady;
    logic        halted;
    logic [35:0] arIn;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expCmdReady;
    logic        expWrReady;
    logic        expRdValid;
    logic [11:0] expRdData;
    logic        expOverride;
    logic        expBusy;
    logic        chkAr;
    logic [35:0] expAr;
  } vec_t;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model: deposit chunks and examine chunks held as queues.
  int          mKind = K_IDLE;
  bit          mErr = 1'b0;
  logic [11:0] mChunks[$];
  logic [11:0] mSend[$];
  logic [35:0] mStaged = '0;
  bit          mArKnown = 1'b0;
  int          mWaited = 0;
  logic [35:0] arWord = AR_DEFAULT;

  function automatic void compare(string name, logic [35:0] act, logic [35:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0o expected=%0o", name, act, exp);
    end
  endfunction

  function automatic void modelStep(stim_t s);
    bit abort;
    abort = s.cmdValid && (s.cmdOp == 2'b11);
    if (s.rst) begin
      mKind = K_IDLE; mErr = 1'b0; mChunks.delete(); mSend.delete();
      mStaged = '0; mArKnown = 1'b1; mWaited = 0;
      return;
    end
    case (mKind)
      K_IDLE: if (s.cmdValid) begin
        mErr = 1'b0;
        if (s.cmdOp == 2'b01) begin
          mKind = K_COLLECT; mChunks.delete(); mArKnown = 1'b0;
        end else if (s.cmdOp == 2'b10) begin
          mKind = K_CAPTURE; mArKnown = 1'b0;
        end
      end
      K_COLLECT: if (abort) begin
        mKind = K_IDLE; mErr = 1'b1;
      end else if (s.wrValid) begin
        mChunks.push_back(s.wrData);
        if (mChunks.size() == 3) begin
          mStaged = {mChunks[0], mChunks[1], mChunks[2]};
          mArKnown = 1'b1; mKind = K_ARM; mWaited = 0;
        end
      end
      K_ARM: if (abort) begin
        mKind = K_IDLE; mErr = 1'b1;
      end else if (s.halted) begin
        mKind = K_OVR;
      end else begin
        mWaited++;
        if (mWaited == ARM_TMO) begin
          mKind = K_IDLE; mErr = 1'b1;
        end
      end
      K_OVR: mKind = K_IDLE;
      K_CAPTURE: begin
        mSend.delete();
        for (int k = 0; k < 3; k++) mSend.push_back(12'(s.arIn >> (12 * (2 - k))));
        mKind = K_SEND;
      end
      K_SEND: if (abort) begin
        mKind = K_IDLE; mErr = 1'b1; mSend.delete();
      end else if (s.rdReady) begin
        void'(mSend.pop_front());
        if (mSend.size() == 0) mKind = K_IDLE;
      end
      default: mKind = K_IDLE;
    endcase
  endfunction

  task automatic checkOutput();
    compare("cmd_ready", 36'(cmd_ready), 36'(mKind == K_IDLE));
    compare("wr_ready", 36'(wr_ready), 36'(mKind == K_COLLECT));
    compare("rd_valid", 36'(rd_valid), 36'(mKind == K_SEND));
    compare("override_ar", 36'(override_ar), 36'(mKind == K_OVR));
    compare("busy", 36'(busy), 36'(mKind != K_IDLE));
    compare("err", 36'(err), 36'(mErr));
    if (mKind == K_SEND) compare("rd_data", 36'(rd_data), 36'(mSend[0]));
    if (mArKnown) compare("ar_value", ar_value, mStaged);
  endtask

  task automatic applyStimulus(stim_t s, bit doCheck);
    reset = s.rst; cmd_valid = s.cmdValid; cmd_op = s.cmdOp;
    wr_valid = s.wrValid; wr_data = s.wrData; rd_ready = s.rdReady;
    ebox_halted = s.halted; ar_in = s.arIn;
    @(negedge clk);
    if (doCheck) checkOutput();
    @(posedge clk);
    modelStep(s);
    #1;
  endtask

  function automatic stim_t quietStim(logic halted);
    stim_t s;
    s.rst = 1'b0; s.cmdValid = 1'b0; s.cmdOp = 2'b00; s.wrValid = 1'b0;
    s.wrData = '0; s.rdReady = 1'b0; s.halted = halted; s.arIn = arWord;
    return s;
  endfunction

  task automatic sendCmd(logic [1:0] op, logic halted);
    stim_t s = quietStim(halted);
    s.cmdValid = 1'b1; s.cmdOp = op;
    applyStimulus(s, 1'b1);
  endtask

  task automatic sendChunk(logic [11:0] d, logic halted);
    stim_t s = quietStim(halted);
    s.wrValid = 1'b1; s.wrData = d;
    applyStimulus(s, 1'b1);
  endtask

  task automatic readCycle(logic ready);
    stim_t s = quietStim(1'b1);
    s.rdReady = ready;
    applyStimulus(s, 1'b1);
  endtask

  task automatic doReset(logic halted);
    stim_t s = quietStim(halted);
    s.rst = 1'b1;
    applyStimulus(s, 1'b1);
  endtask

  task automatic checkIdleAfterReset(string tag);
    compare({tag, "_cmd_ready"}, 36'(cmd_ready), 36'd1);
    compare({tag, "_busy"}, 36'(busy), 36'd0);
    compare({tag, "_override_ar"}, 36'(override_ar), 36'd0);
    compare({tag, "_wr_ready"}, 36'(wr_ready), 36'd0);
    compare({tag, "_rd_valid"}, 36'(rd_valid), 36'd0);
    compare({tag, "_rd_data"}, 36'(rd_data), 36'd0);
    compare({tag, "_err"}, 36'(err), 36'd0);
    compare({tag, "_ar_value"}, ar_value, 36'd0);
  endtask

  function automatic vec_t mkVec(logic cv, logic [1:0] op, logic wv, logic [11:0] wd, logic rr,
                                 logic eReady, logic eWr, logic eRdV, logic [11:0] eRd,
                                 logic eOvr, logic eBusy, logic chk, logic [35:0] eAr);
    vec_t v;
    v.s = quietStim(1'b1);
    v.s.cmdValid = cv; v.s.cmdOp = op; v.s.wrValid = wv; v.s.wrData = wd; v.s.rdReady = rr;
    v.expCmdReady = eReady; v.expWrReady = eWr; v.expRdValid = eRdV; v.expRdData = eRd;
    v.expOverride = eOvr; v.expBusy = eBusy; v.chkAr = chk; v.expAr = eAr;
    return v;
  endfunction

  task automatic checkVector(int i, vec_t v);
    compare($sformatf("vec%0d_cmd_ready", i), 36'(cmd_ready), 36'(v.expCmdReady));
    compare($sformatf("vec%0d_wr_ready", i), 36'(wr_ready), 36'(v.expWrReady));
    compare($sformatf("vec%0d_rd_valid", i), 36'(rd_valid), 36'(v.expRdValid));
    compare($sformatf("vec%0d_override_ar", i), 36'(override_ar), 36'(v.expOverride));
    compare($sformatf("vec%0d_busy", i), 36'(busy), 36'(v.expBusy));
    compare($sformatf("vec%0d_err", i), 36'(err), 36'd0);
    if (v.expRdValid) compare($sformatf("vec%0d_rd_data", i), 36'(rd_data), 36'(v.expRdData));
    if (v.chkAr) compare($sformatf("vec%0d_ar_value", i), ar_value, v.expAr);
  endtask

  initial begin
    vec_t  vecs[12];
    stim_t s;
    int    cyc;
    bit    ovrSeen;
    bit    haltedNow;

    // Deposit 7777/0000/1234 while halted, then examine 36'o123456765432 with rd_ready high.
    vecs[0]  = mkVec(1, 2'b01, 0, 12'o0000, 0, 1, 0, 0, 12'o0000, 0, 0, 1, 36'o000000000000);
    vecs[1]  = mkVec(0, 2'b00, 1, 12'o7777, 0, 0, 1, 0, 12'o0000, 0, 1, 1, 36'o000000000000);
    vecs[2]  = mkVec(0, 2'b00, 1, 12'o0000, 0, 0, 1, 0, 12'o0000, 0, 1, 1, 36'o777700000000);
    vecs[3]  = mkVec(0, 2'b00, 1, 12'o1234, 0, 0, 1, 0, 12'o0000, 0, 1, 1, 36'o777700000000);
    vecs[4]  = mkVec(0, 2'b00, 0, 12'o0000, 0, 0, 0, 0, 12'o0000, 0, 1, 1, 36'o777700001234);
    vecs[5]  = mkVec(0, 2'b00, 0, 12'o0000, 0, 0, 0, 0, 12'o0000, 1, 1, 1, 36'o777700001234);
    vecs[6]  = mkVec(1, 2'b10, 0, 12'o0000, 1, 1, 0, 0, 12'o0000, 0, 0, 1, 36'o777700001234);
    vecs[7]  = mkVec(0, 2'b00, 0, 12'o0000, 1, 0, 0, 0, 12'o0000, 0, 1, 1, 36'o777700001234);
    vecs[8]  = mkVec(0, 2'b00, 0, 12'o0000, 1, 0, 0, 1, 12'o1234, 0, 1, 0, 36'o0);
    vecs[9]  = mkVec(0, 2'b00, 0, 12'o0000, 1, 0, 0, 1, 12'o5676, 0, 1, 0, 36'o0);
    vecs[10] = mkVec(0, 2'b00, 0, 12'o0000, 1, 0, 0, 1, 12'o5432, 0, 1, 0, 36'o0);
    vecs[11] = mkVec(0, 2'b00, 0, 12'o0000, 0, 1, 0, 0, 12'o0000, 0, 0, 0, 36'o0);

    s = quietStim(1'b1);
    s.rst = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    checkIdleAfterReset("reset");

    for (int i = 0; i < 12; i++) begin
      checkVector(i, vecs[i]);
      applyStimulus(vecs[i].s, 1'b1);
    end

    // Timeout: ebox never halts while armed.
    sendCmd(2'b01, 1'b0);
    sendChunk(12'o1111, 1'b0);
    sendChunk(12'o2222, 1'b0);
    sendChunk(12'o3333, 1'b0);
    cyc = 0;
    ovrSeen = 1'b0;
    while (busy && cyc < ARM_TMO + 20) begin
      if (override_ar) ovrSeen = 1'b1;
      applyStimulus(quietStim(1'b0), 1'b1);
      cyc++;
    end
    compare("tmo_arm_cycles", 36'(cyc), 36'(ARM_TMO));
    compare("tmo_idle", 36'(busy), 36'd0);
    compare("tmo_err", 36'(err), 36'd1);
    compare("tmo_no_override", 36'(ovrSeen), 36'd0);

    // Examine with the front end stalling on chunk 1.
    arWord = 36'o765432101234;
    sendCmd(2'b10, 1'b1);
    compare("exam_err_cleared", 36'(err), 36'd0);
    readCycle(1'b1);
    compare("stall_chunk0", 36'(rd_data), 36'o7654);
    readCycle(1'b1);
    for (int i = 0; i < 5; i++) begin
      compare("stall_rd_valid", 36'(rd_valid), 36'd1);
      compare("stall_rd_data", 36'(rd_data), 36'o3210);
      readCycle(1'b0);
    end
    readCycle(1'b1);
    compare("stall_chunk2", 36'(rd_data), 36'o1234);
    readCycle(1'b1);
    compare("stall_done", 36'(busy), 36'd0);
    arWord = AR_DEFAULT;

    // ABORT after two chunks, colliding with a third chunk; then a fresh deposit.
    sendCmd(2'b01, 1'b1);
    sendChunk(12'o1111, 1'b1);
    sendChunk(12'o2222, 1'b1);
    s = quietStim(1'b1);
    s.cmdValid = 1'b1; s.cmdOp = 2'b11; s.wrValid = 1'b1; s.wrData = 12'o3333;
    applyStimulus(s, 1'b1);
    compare("abort_err", 36'(err), 36'd1);
    compare("abort_idle", 36'(busy), 36'd0);
    sendCmd(2'b01, 1'b1);
    compare("redeposit_err_clear", 36'(err), 36'd0);
    sendChunk(12'o4444, 1'b1);
    sendChunk(12'o5555, 1'b1);
    sendChunk(12'o6666, 1'b1);
    applyStimulus(quietStim(1'b1), 1'b1);
    compare("redeposit_override", 36'(override_ar), 36'd1);
    compare("redeposit_ar_value", ar_value, 36'o444455556666);
    applyStimulus(quietStim(1'b1), 1'b1);

    // Reset while armed, with halted rising on the same edge.
    sendCmd(2'b01, 1'b0);
    sendChunk(12'o0123, 1'b0);
    sendChunk(12'o4567, 1'b0);
    sendChunk(12'o7070, 1'b0);
    applyStimulus(quietStim(1'b0), 1'b1);
    applyStimulus(quietStim(1'b0), 1'b1);
    doReset(1'b1);
    checkIdleAfterReset("rst_arm");

    // Reset while sending examine chunks.
    sendCmd(2'b10, 1'b1);
    readCycle(1'b1);
    readCycle(1'b1);
    compare("rst_send_pre", 36'(rd_valid), 36'd1);
    doReset(1'b1);
    checkIdleAfterReset("rst_send");

    // Randomized traffic against the model.
    haltedNow = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) haltedNow = ~haltedNow;
      s = quietStim(haltedNow);
      s.rst      = ($urandom_range(0, 299) == 0);
      s.cmdValid = ($urandom_range(0, 3) == 0);
      s.cmdOp    = 2'($urandom_range(0, 3));
      if (s.cmdOp == 2'b11 && $urandom_range(0, 2) != 0) s.cmdOp = 2'b01;
      s.wrValid  = $urandom_range(0, 1) == 1;
      s.wrData   = 12'($urandom);
      s.rdReady  = $urandom_range(0, 2) != 0;
      s.arIn     = 36'({$urandom, $urandom});
      applyStimulus(s, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
